// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single word-read memory port.
// One transaction in flight; illegal addresses are answered locally with err.
module mem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT  = 32'h0000_1000,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  input  logic [31:0] m0_addr_i,
  output logic        m0_resp_valid_o,
  input  logic        m0_resp_ready_i,
  output logic [31:0] m0_data_o,
  output logic        m0_err_o,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  input  logic [31:0] m1_addr_i,
  output logic        m1_resp_valid_o,
  input  logic        m1_resp_ready_i,
  output logic [31:0] m1_data_o,
  output logic        m1_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        win_m0, win_m1, accept;
  logic [31:0] sel_addr;

  function automatic logic addr_legal(input logic [31:0] a);
    logic ok;
    ok = (a < ADDR_LIMIT);
    if (CHECK_ALIGN && (a[1:0] != 2'b00)) ok = 1'b0;
    return ok;
  endfunction

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    owner_d          = owner_q;
    err_d            = err_q;
    addr_d           = addr_q;
    data_d           = data_q;
    m0_req_ready_o   = 1'b0;
    m1_req_ready_o   = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_addr_o       = '0;
    mem_resp_ready_o = 1'b0;
    accept           = 1'b0;
    // On a tie the requester that was not served last wins.
    win_m0   = m0_req_valid_i && (!m1_req_valid_i || last_grant_q);
    win_m1   = m1_req_valid_i && (!m0_req_valid_i || !last_grant_q);
    sel_addr = win_m1 ? m1_addr_i : m0_addr_i;

    case (state_q)
      IDLE: begin
        m0_req_ready_o = !rst && win_m0;
        m1_req_ready_o = !rst && win_m1;
        accept         = m0_req_ready_o || m1_req_ready_o;
        if (accept) begin
          owner_d = win_m1;
          addr_d  = sel_addr;
          if (addr_legal(sel_addr)) begin
            state_d = ISSUE;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RETURN;
          end
        end
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = addr_q;
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          data_d  = mem_data_i;
          err_d   = 1'b0;
          state_d = RETURN;
        end
      end
      RETURN: begin
        if (owner_q ? m1_resp_ready_i : m0_resp_ready_i) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
    end
  end

  // Address and read data are only observed once qualified by state, so no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign m0_resp_valid_o = (state_q == RETURN) && !owner_q;
  assign m1_resp_valid_o = (state_q == RETURN) && owner_q;
  assign m0_data_o       = m0_resp_valid_o ? data_q : '0;
  assign m1_data_o       = m1_resp_valid_o ? data_q : '0;
  assign m0_err_o        = m0_resp_valid_o && err_q;
  assign m1_err_o        = m1_resp_valid_o && err_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected responses,
// a monitor pops them on each response handshake; a small memory model answers.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid_i, m0_req_ready_o, m0_resp_valid_o, m0_resp_ready_i, m0_err_o;
  logic [31:0] m0_addr_i, m0_data_o;
  logic        m1_req_valid_i, m1_req_ready_o, m1_resp_valid_o, m1_resp_ready_i, m1_err_o;
  logic [31:0] m1_addr_i, m1_data_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_resp_valid_i, mem_resp_ready_o, busy_o;
  logic [31:0] mem_addr_o, mem_data_i;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o), .m0_addr_i(m0_addr_i),
    .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready_i),
    .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o), .m1_addr_i(m1_addr_i),
    .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready_i),
    .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_ready_o(mem_resp_ready_o), .mem_data_i(mem_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          mem_req_stall = 0;
  int          mem_resp_delay = 0;
  int          mem_hs = 0;
  bit          sat_on = 1'b0;
  bit          hold0 = 1'b0, hold1 = 1'b0;
  logic [31:0] hold_d0, hold_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0190: return 32'h2000_0001;
      32'h0000_0320: return 32'h3000_0001;
      default:       return 32'hA5A5_0000 | a;
    endcase
  endfunction

  task automatic push_exp(input int id, input logic [31:0] d, input logic e);
    exp_t x;
    x.id = id; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic drive_req(input int id, input logic [31:0] a);
    int  n;
    bit  rdy;
    n = 0;
    if (id == 0) begin m0_req_valid_i = 1'b1; m0_addr_i = a; end
    else         begin m1_req_valid_i = 1'b1; m1_addr_i = a; end
    forever begin
      @(negedge clk);
      rdy = (id == 0) ? m0_req_ready_o : m1_req_ready_o;
      if (rdy) break;
      n++;
      if (n > 300) begin
        errors++; checks++;
        $display("FAIL req_accept_timeout: requester %0d addr %h never accepted", id, a);
        break;
      end
    end
    @(posedge clk); #1;
    if (id == 0) m0_req_valid_i = 1'b0; else m1_req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      errors++; checks++;
      $display("FAIL drain_timeout: %0d responses still pending, busy=%0b", sb.size(), busy_o);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m0_req_ready"},  {31'b0, m0_req_ready_o}, 0);
    chk({tag, "_m1_req_ready"},  {31'b0, m1_req_ready_o}, 0);
    chk({tag, "_m0_resp_valid"}, {31'b0, m0_resp_valid_o}, 0);
    chk({tag, "_m1_resp_valid"}, {31'b0, m1_resp_valid_o}, 0);
    chk({tag, "_m0_data"},       m0_data_o, 0);
    chk({tag, "_m1_data"},       m1_data_o, 0);
    chk({tag, "_errs"},          {30'b0, m0_err_o, m1_err_o}, 0);
    chk({tag, "_mem_req_valid"}, {31'b0, mem_req_valid_o}, 0);
    chk({tag, "_mem_addr"},      mem_addr_o, 0);
    chk({tag, "_mem_resp_ready"},{31'b0, mem_resp_ready_o}, 0);
    chk({tag, "_busy"},          {31'b0, busy_o}, 0);
  endtask

  task automatic mon_resp(input int id, input logic v, input logic r,
                          input logic [31:0] d, input logic e);
    exp_t x;
    bit   h;
    h = (id == 0) ? hold0 : hold1;
    if (!v) begin
      if (id == 0) hold0 = 1'b0; else hold1 = 1'b0;
      return;
    end
    if (h) chk("resp_data_stable", d, (id == 0) ? hold_d0 : hold_d1);
    if (r) begin
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_resp: requester %0d data %h err %0b", id, d, e);
      end else begin
        x = sb.pop_front();
        chk("resp_owner", id, x.id);
        chk("resp_data", d, x.data);
        chk("resp_err", {31'b0, e}, {31'b0, x.err});
      end
      if (id == 0) hold0 = 1'b0; else hold1 = 1'b0;
    end else begin
      if (id == 0) begin hold0 = 1'b1; hold_d0 = d; end
      else         begin hold1 = 1'b1; hold_d1 = d; end
    end
  endtask

  // Response monitor and busy/ready invariants.
  initial begin
    int  idle_run;
    bit  seen_busy;
    idle_run = 0; seen_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold0 = 1'b0; hold1 = 1'b0;
        continue;
      end
      if (m0_resp_valid_o && m1_resp_valid_o) begin
        errors++; checks++;
        $display("FAIL both_resp_valid: m0 and m1 responses asserted together");
      end
      if (!m0_resp_valid_o) chk("m0_data_idle", m0_data_o, 0);
      if (!m1_resp_valid_o) chk("m1_data_idle", m1_data_o, 0);
      if (busy_o) chk("ready_while_busy", {30'b0, m0_req_ready_o, m1_req_ready_o}, 0);
      mon_resp(0, m0_resp_valid_o, m0_resp_ready_i, m0_data_o, m0_err_o);
      mon_resp(1, m1_resp_valid_o, m1_resp_ready_i, m1_data_o, m1_err_o);
      if (!sat_on) begin
        idle_run = 0; seen_busy = 1'b0;
      end else if (!busy_o) begin
        idle_run++;
      end else begin
        if (seen_busy && idle_run > 0) chk("sat_idle_gap", idle_run, 1);
        idle_run = 0; seen_busy = 1'b1;
      end
    end
  end

  // Memory model: optional request stall and response delay, dropped on reset.
  initial begin
    int          mph, mstall, mdly;
    logic [31:0] maddr;
    mph = 0; mstall = 0; mdly = 0; maddr = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mph = 0; mstall = 0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_data_i = '0;
        continue;
      end
      case (mph)
        0: begin
          if (mstall > 0) begin
            chk("mem_req_valid_hold", {31'b0, mem_req_valid_o}, 1);
            chk("mem_addr_hold", mem_addr_o, maddr);
          end
          if (mem_req_valid_o) begin
            if (mstall == 0) maddr = mem_addr_o;
            if (mstall < mem_req_stall) mstall++;
            else begin
              mem_req_ready_i = 1'b1;
              mem_hs++;
              mph = 1;
            end
          end
        end
        1: begin
          mem_req_ready_i = 1'b0; mstall = 0; mdly = 0; mph = 2;
        end
        2: begin
          if (mdly < mem_resp_delay) mdly++;
          else begin
            mem_resp_valid_i = 1'b1; mem_data_i = mem_val(maddr); mph = 3;
          end
        end
        default: begin
          mem_resp_valid_i = 1'b0; mem_data_i = '0; mph = 0;
        end
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n, hs0;
    rst = 1'b1;
    m0_req_valid_i = 1'b1; m0_addr_i = 32'h190; m0_resp_ready_i = 1'b1;
    m1_req_valid_i = 1'b1; m1_addr_i = 32'h320; m1_resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Single request with latency check on the memory side.
    push_exp(0, 32'h2000_0001, 1'b0);
    drive_req(0, 32'h190);
    chk("issue_latency_valid", {31'b0, mem_req_valid_o}, 1);
    chk("issue_addr", mem_addr_o, 32'h190);
    wait_drain();

    // Tie right after reset: m0 first, then m1.
    do_reset(2);
    push_exp(0, 32'h2000_0001, 1'b0);
    push_exp(1, 32'h3000_0001, 1'b0);
    fork
      drive_req(0, 32'h190);
      drive_req(1, 32'h320);
    join
    wait_drain();

    // Saturation: grants alternate starting with m0.
    sat_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 32'h2000_0001, 1'b0);
      push_exp(1, 32'h3000_0001, 1'b0);
    end
    fork
      begin for (int i = 0; i < 3; i++) drive_req(0, 32'h190); end
      begin for (int j = 0; j < 3; j++) drive_req(1, 32'h320); end
    join
    wait_drain();
    sat_on = 1'b0;

    // Error paths never reach memory and answer one cycle after acceptance.
    hs0 = mem_hs;
    push_exp(0, 32'h0, 1'b1);
    drive_req(0, 32'h1000);
    chk("err_resp_latency", {31'b0, m0_resp_valid_o}, 1);
    chk("err_no_mem_req", {31'b0, mem_req_valid_o}, 0);
    wait_drain();
    push_exp(1, 32'h0, 1'b1);
    drive_req(1, 32'h191);
    chk("misalign_resp_latency", {31'b0, m1_resp_valid_o}, 1);
    wait_drain();
    push_exp(1, 32'h0, 1'b1);
    drive_req(1, 32'hFFFF_FFFC);
    wait_drain();
    chk("err_mem_untouched", mem_hs, hs0);
    push_exp(0, 32'hA5A5_0FFC, 1'b0);
    drive_req(0, 32'hFFC);
    wait_drain();
    chk("legal_top_word_mem", mem_hs, hs0 + 1);

    // Memory request backpressure.
    mem_req_stall = 3;
    push_exp(0, 32'h3000_0001, 1'b0);
    drive_req(0, 32'h320);
    wait_drain();
    mem_req_stall = 0;

    // Response backpressure on m1 while m0 waits.
    m1_resp_ready_i = 1'b0;
    push_exp(1, 32'h2000_0001, 1'b0);
    push_exp(0, 32'h3000_0001, 1'b0);
    drive_req(1, 32'h190);
    fork
      drive_req(0, 32'h320);
      begin
        n = 0;
        while (!m1_resp_valid_o && n < 100) begin @(posedge clk); #1; n++; end
        chk("m1_resp_seen", {31'b0, m1_resp_valid_o}, 1);
        for (int k = 0; k < 4; k++) begin
          chk("m1_resp_valid_stall", {31'b0, m1_resp_valid_o}, 1);
          chk("m1_data_stall", m1_data_o, 32'h2000_0001);
          chk("m0_blocked", {31'b0, m0_req_ready_o}, 0);
          @(posedge clk); #1;
        end
        m1_resp_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Reset while waiting on memory drops the transaction.
    mem_resp_delay = 6;
    drive_req(0, 32'h190);
    n = 0;
    while (!mem_resp_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("reached_wait", {31'b0, mem_resp_ready_o}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1 rst = 1'b0;
    mem_resp_delay = 0;
    push_exp(1, 32'h3000_0001, 1'b0);
    drive_req(1, 32'h320);
    wait_drain();
    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
